// File: rtl/video_linedbl_pkg.sv
// Shared constants and helpers for the line-buffer scandoubler.
// It provides the default geometry, a constant-evaluable ceil(log2) and the
// tag that travels alongside each RAM read.
package video_linedbl_pkg;

  localparam int DEF_COMP_W   = 2;
  localparam int DEF_LINE_MAX = 448;
  localparam int DEF_BANKS    = 2;

  // Number of address bits needed to index 'value' distinct entries.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // True when 'value' is a non-zero power of two.
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Per-pixel side information that travels with the RAM read.
  typedef struct packed {
    logic valid;  // address was inside the held line
    logic dim;    // apply scanline dimming to this pixel
  } rd_tag_t;

endpackage

// File: rtl/video_linedbl_mem.sv
// Simple dual-port line RAM: BANKS lines of LINE_MAX pixels each.
// Writes are synchronous. Reads are registered, with one cycle of latency.
// The flat address is {bank, ptr} when LINE_MAX is a power of two, and
// bank*LINE_MAX+ptr otherwise, so the array stays dense.
module video_linedbl_mem
  import video_linedbl_pkg::*;
#(
  parameter int PIX_W    = 3 * DEF_COMP_W,
  parameter int LINE_MAX = DEF_LINE_MAX,
  parameter int BANKS    = DEF_BANKS
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [clog2(BANKS)-1:0]      wr_bank,
  input  logic [clog2(LINE_MAX+1)-1:0] wr_ptr,
  input  logic [PIX_W-1:0]             wr_data,
  input  logic                         rd_en,
  input  logic [clog2(BANKS)-1:0]      rd_bank,
  input  logic [clog2(LINE_MAX+1)-1:0] rd_ptr,
  output logic [PIX_W-1:0]             rd_data
);

  localparam int DEPTH  = BANKS * LINE_MAX;
  localparam int ADDR_W = clog2(DEPTH);
  localparam int LOG_L  = clog2(LINE_MAX);

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  mem [DEPTH];

  generate
    if (is_pow2(LINE_MAX)) begin : g_concat
      assign wr_addr = ADDR_W'({wr_bank, wr_ptr[LOG_L-1:0]});
      assign rd_addr = ADDR_W'({rd_bank, rd_ptr[LOG_L-1:0]});
    end else begin : g_linear
      localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_MAX);
      assign wr_addr = ADDR_W'(wr_bank) * STRIDE + ADDR_W'(wr_ptr);
      assign rd_addr = ADDR_W'(rd_bank) * STRIDE + ADDR_W'(rd_ptr);
    end
  endgenerate

  // Synchronous write port.
  // NOTE: the storage array has no reset. Resetting it would stop block-RAM
  // inference, and every read that matters is qualified by a reset valid tag.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port. rd_data holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/video_linedbl.sv
// Line-buffer scandoubler. It captures one TV-rate scanline into a ring of
// line banks, then replays each completed line twice at VGA rate. The second
// replay can be dimmed as a scanline effect. It also reports the length of the
// replayed line and flags pixels that were dropped because the line was full.
module video_linedbl
  import video_linedbl_pkg::*;
#(
  parameter int COMP_W   = DEF_COMP_W,
  parameter int LINE_MAX = DEF_LINE_MAX,
  parameter int BANKS    = DEF_BANKS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hsync_start,
  input  logic                         scanin_start,
  input  logic                         scanout_start,
  input  logic                         pix_in_stb,
  input  logic [3*COMP_W-1:0]          pix_in,
  input  logic                         scanlines_ena,
  input  logic                         ovf_clr,
  output logic [3*COMP_W-1:0]          pix_out,
  output logic [clog2(LINE_MAX+1)-1:0] line_len,
  output logic                         wr_ovf
);

  localparam int PIX_W  = 3 * COMP_W;
  localparam int PTR_W  = clog2(LINE_MAX + 1);
  localparam int BANK_W = clog2(BANKS);

  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(LINE_MAX);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANKS - 1);

  // Write-side state.
  logic [PTR_W-1:0]  wr_ptr;
  logic [BANK_W-1:0] wr_bank;

  // Read-side state.
  logic [BANK_W-1:0] rd_bank;
  logic [PTR_W-1:0]  rd_len;
  logic [PTR_W-1:0]  rd_ptr;
  logic              half;
  logic              armed;   // an hsync has happened since the last scanout_start
  logic              primed;  // at least one hsync since reset; the first captured line is partial

  // Values for this cycle, after this cycle's pulses are applied.
  logic [PTR_W-1:0]  wr_base;
  logic              wr_en;
  logic              wr_drop;
  logic [PTR_W-1:0]  wr_next;
  logic [BANK_W-1:0] bank_next;
  logic [BANK_W-1:0] rd_bank_eff;
  logic [PTR_W-1:0]  rd_len_eff;
  logic [PTR_W-1:0]  rd_ptr_eff;
  logic              armed_eff;
  logic              half_eff;
  logic              rd_valid;

  // Read pipeline.
  rd_tag_t           tag_d;
  rd_tag_t           tag_q;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  pix_dim;

  // Resolve this cycle's pulses. A same-cycle hsync takes effect before the
  // read, so a coincident scanout_start already replays the new line.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    wr_base     = scanin_start ? '0 : wr_ptr;
    wr_en       = pix_in_stb && (wr_base < PTR_MAX);
    wr_drop     = pix_in_stb && !wr_en;
    wr_next     = wr_en ? wr_base + PTR_W'(1) : wr_base;
    bank_next   = (wr_bank == BANK_LAST) ? '0 : wr_bank + BANK_W'(1);

    rd_bank_eff = hsync_start ? wr_bank : rd_bank;
    rd_len_eff  = rd_len;
    if (hsync_start) rd_len_eff = primed ? wr_next : '0;
    rd_ptr_eff  = scanout_start ? '0 : rd_ptr;
    armed_eff   = hsync_start | armed;
    half_eff    = hsync_start | half;
    if (scanout_start) half_eff = !armed_eff;
    rd_valid    = rd_ptr_eff < rd_len_eff;

    tag_d.valid = rd_valid;
    tag_d.dim   = scanlines_ena & half_eff;
  end

  // Capture pointer, bank rotation and the sticky overflow flag.
  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_bank <= '0;
      wr_ovf  <= 1'b0;
    end else begin
      wr_ptr <= hsync_start ? '0 : wr_next;
      if (hsync_start) wr_bank <= bank_next;
      if (wr_drop)      wr_ovf <= 1'b1;
      else if (ovf_clr) wr_ovf <= 1'b0;
    end
  end

  // Replay pointer, the held line and the half-line marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank <= BANK_LAST;
      rd_len  <= '0;
      rd_ptr  <= PTR_MAX;
      half    <= 1'b1;
      armed   <= 1'b0;
      primed  <= 1'b0;
    end else begin
      rd_bank <= rd_bank_eff;
      rd_len  <= rd_len_eff;
      rd_ptr  <= rd_valid ? rd_ptr_eff + PTR_W'(1) : rd_ptr_eff;
      half    <= half_eff;
      armed   <= armed_eff & !scanout_start;
      primed  <= primed | hsync_start;
    end
  end

  video_linedbl_mem #(
    .PIX_W    (PIX_W),
    .LINE_MAX (LINE_MAX),
    .BANKS    (BANKS)
  ) u_mem (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_ptr   (wr_base),
    .wr_data  (pix_in),
    .rd_en    (rd_valid),
    .rd_bank  (rd_bank_eff),
    .rd_ptr   (rd_ptr_eff),
    .rd_data  (rd_data)
  );

  // Halve each colour component to dim the scanline.
  always_comb begin
    pix_dim = '0;
    for (int c = 0; c < 3; c++) begin
      pix_dim[c*COMP_W +: COMP_W] = rd_data[c*COMP_W +: COMP_W] >> 1;
    end
  end

  // Carry the tag alongside the RAM read and register the output pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      pix_out <= '0;
    end else begin
      tag_q   <= tag_d;
      pix_out <= !tag_q.valid ? '0 : (tag_q.dim ? pix_dim : rd_data);
    end
  end

  assign line_len = rd_len;

endmodule
